// File: rtl/aidc_lite_zrle_pkg.sv
// Shared ZRLE definitions: control-token field positions, block geometry and compressor FSM states.
// Imported by both the ZRLE compressor and the ZRLE decompressor so the token format stays bit-exact.
package aidc_lite_zrle_pkg;

    localparam int HAS_LIT_BIT     = 31;
    localparam int RUN_MSB         = 5;
    localparam int WORDS_PER_BLOCK = 32;
    localparam int LAST_ENTRY      = WORDS_PER_BLOCK / 2 - 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SCAN_LO,
        ST_SCAN_HI,
        ST_W_CTRL,
        ST_W_LIT,
        ST_END,
        ST_W_TAIL,
        ST_DONE
    } zrle_state_t;

    function automatic logic [31:0] ctrl_tok(input logic has_lit, input logic [RUN_MSB:0] run);
        logic [31:0] t;
        t              = '0;
        t[HAS_LIT_BIT] = has_lit;
        t[RUN_MSB:0]   = run;
        return t;
    endfunction

endpackage

// File: rtl/aidc_lite_comp_zrle.sv
// Zero-run-length compressor for one 128-byte block into a framed 32-bit token stream.
// Latency: 3 cycles per buffer entry while scanning; first token of an all-zero block at cycle 49.
// Backpressure: tokens held stable while valid_o & !ready_i; scanning pauses during emission.
// Optional AIDC_LITE_COMP_ZRLE_STAT_EN adds a token counter reported on comp_words_o.
module aidc_lite_comp_zrle (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic [3:0]  buf_addr_o,
    input  logic [63:0] buf_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sop_o,
    output logic        eop_o,
    output logic [31:0] data_o,
    output logic        done_o,
    output logic [6:0]  comp_words_o
);
    import aidc_lite_zrle_pkg::*;

    zrle_state_t        r_state;
    logic [3:0]         r_entry;
    logic [RUN_MSB:0]   r_run;
    logic               r_first;
    logic               r_hi;
    logic [31:0]        r_word_hi;
    logic [31:0]        r_lit;
    logic               r_valid;
    logic               r_sop;
    logic               r_eop;
    logic [31:0]        r_data;
    logic               r_done;

    logic               w_hs;
    logic               w_last_entry;
    logic [31:0]        w_lo_word;

    assign w_hs         = r_valid & ready_i;
    assign w_last_entry = (r_entry == 4'(LAST_ENTRY));
    assign w_lo_word    = buf_rdata_i[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_entry   <= '0;
            r_run     <= '0;
            r_first   <= 1'b0;
            r_hi      <= 1'b0;
            r_word_hi <= '0;
            r_lit     <= '0;
            r_valid   <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_entry <= '0;
                        r_run   <= '0;
                        r_first <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_SCAN_LO;
                ST_SCAN_LO: begin
                    r_word_hi <= buf_rdata_i[63:32];
                    if (w_lo_word == '0) begin
                        r_run   <= r_run + 1'b1;
                        r_state <= ST_SCAN_HI;
                    end else begin
                        r_lit   <= w_lo_word;
                        r_hi    <= 1'b0;
                        r_valid <= 1'b1;
                        r_data  <= ctrl_tok(1'b1, r_run);
                        r_sop   <= r_first;
                        r_eop   <= 1'b0;
                        r_run   <= '0;
                        r_state <= ST_W_CTRL;
                    end
                end
                ST_SCAN_HI: begin
                    if (r_word_hi == '0) begin
                        r_run <= r_run + 1'b1;
                        if (w_last_entry) begin
                            r_state <= ST_END;
                        end else begin
                            r_entry <= r_entry + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_lit   <= r_word_hi;
                        r_hi    <= 1'b1;
                        r_valid <= 1'b1;
                        r_data  <= ctrl_tok(1'b1, r_run);
                        r_sop   <= r_first;
                        r_eop   <= 1'b0;
                        r_run   <= '0;
                        r_state <= ST_W_CTRL;
                    end
                end
                ST_W_CTRL: begin
                    if (w_hs) begin
                        r_first <= 1'b0;
                        r_data  <= r_lit;
                        r_sop   <= 1'b0;
                        // Word 31 literal closes the block: no tail token can follow it.
                        r_eop   <= r_hi & w_last_entry;
                        r_state <= ST_W_LIT;
                    end
                end
                ST_W_LIT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b0;
                        if (!r_hi) begin
                            r_state <= ST_SCAN_HI;
                        end else if (w_last_entry) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_entry <= r_entry + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_END: begin
                    if (r_run != '0) begin
                        r_valid <= 1'b1;
                        r_data  <= ctrl_tok(1'b0, r_run);
                        r_sop   <= r_first;
                        r_eop   <= 1'b1;
                        r_state <= ST_W_TAIL;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_W_TAIL: begin
                    if (w_hs) begin
                        r_first <= 1'b0;
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign buf_addr_o = r_entry;
    assign valid_o    = r_valid;
    assign sop_o      = r_sop;
    assign eop_o      = r_eop;
    assign data_o     = r_data;
    assign done_o     = r_done;

`ifdef AIDC_LITE_COMP_ZRLE_STAT_EN
    logic [6:0] r_cnt;
    logic [6:0] r_comp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_comp <= '0;
        end else begin
            if (r_state == ST_IDLE && start_i) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_comp <= r_cnt;
            end
        end
    end

    assign comp_words_o = r_comp;
`else
    assign comp_words_o = 7'd0;
`endif

endmodule
